// File: rtl/crcdec_pkg.sv
// Shared definitions for the CRC decelerator host: nibble-port command codes,
// host FSM states, sampled configuration record and small width helpers.
package crcdec_pkg;

    localparam int CRC_MAX_WIDTH = 32;
    localparam int SHIFT_CYCLES  = 8;

    typedef enum logic [1:0] {
        CMD_RESET   = 2'd0,
        CMD_SETUP   = 2'd1,
        CMD_MESSAGE = 2'd2,
        CMD_FINAL   = 2'd3
    } dut_cmd_e;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        SETUP_STREAM = 4'd1,
        SETUP_EXIT   = 4'd2,
        MSG_LEAD     = 4'd3,
        MSG_LO       = 4'd4,
        MSG_HI       = 4'd5,
        MSG_SHIFT    = 4'd6,
        FINAL_WAIT   = 4'd7,
        FINAL_CAP    = 4'd8,
        DONE         = 4'd9
    } host_state_e;

    typedef struct packed {
        logic [5:0]  width;
        logic        reflect_in;
        logic        reflect_out;
        logic [31:0] poly;
        logic [31:0] init;
        logic [31:0] xorv;
    } crc_cfg_t;

    localparam crc_cfg_t CFG_RESET = '{
        width:       6'd32,
        reflect_in:  1'b0,
        reflect_out: 1'b0,
        poly:        32'd0,
        init:        32'd0,
        xorv:        32'd0
    };

    // Legal widths: 8..CRC_MAX_WIDTH in steps of one nibble.
    function automatic logic width_legal(input logic [5:0] w);
        return (w[1:0] == 2'b00) && (w >= 6'd8) && (w <= 6'(CRC_MAX_WIDTH));
    endfunction

    // All-ones mask covering the low w bits.
    function automatic logic [31:0] width_mask(input logic [5:0] w);
        if (w >= 6'(CRC_MAX_WIDTH)) begin
            return 32'hFFFF_FFFF;
        end else begin
            return (32'd1 << w) - 32'd1;
        end
    endfunction

    // Number of result bytes returned by the decelerator: ceil(w/8).
    function automatic logic [3:0] width_bytes(input logic [5:0] w);
        return 4'(({1'b0, w} + 7'd7) >> 3);
    endfunction

endpackage

// File: rtl/crcdec_setup_serializer.sv
// Maps a setup-stream nibble index onto the configuration nibble that the
// decelerator expects: index 0 idle, 1/2 config word, then poly, init and xor
// (N = width/4 nibbles each, least-significant nibble first).
module crcdec_setup_serializer
    import crcdec_pkg::*;
(
    input  crc_cfg_t    cfg,
    input  logic [4:0]  idx,
    output logic [3:0]  nibble
);

    logic [5:0] idx6;
    logic [5:0] n6;
    logic [5:0] init_base;
    logic [5:0] xor_base;
    logic [5:0] end_base;

    assign idx6      = {1'b0, idx};
    assign n6        = {2'b00, cfg.width[5:2]};
    assign init_base = 6'd3 + n6;
    assign xor_base  = init_base + n6;
    assign end_base  = xor_base + n6;

    function automatic logic [3:0] nib_of(input logic [31:0] word, input logic [2:0] k);
        return 4'(word >> {k, 2'b00});
    endfunction

    // Select the nibble for the current index from the sampled configuration.
    always_comb begin
        nibble = 4'h0;
        if (idx6 == 6'd1) begin
            nibble = cfg.width[3:0];
        end else if (idx6 == 6'd2) begin
            nibble = {cfg.width[5], cfg.width[4], cfg.reflect_out, cfg.reflect_in};
        end else if ((idx6 >= 6'd3) && (idx6 < init_base)) begin
            nibble = nib_of(cfg.poly, 3'(idx6 - 6'd3));
        end else if ((idx6 >= init_base) && (idx6 < xor_base)) begin
            nibble = nib_of(cfg.init, 3'(idx6 - init_base));
        end else if ((idx6 >= xor_base) && (idx6 < end_base)) begin
            nibble = nib_of(cfg.xorv, 3'(idx6 - xor_base));
        end else begin
            nibble = 4'h0;
        end
    end

endmodule

// File: rtl/crc_decel_host.sv
// Host controller for a nibble-serial CRC decelerator: streams the setup
// record, feeds message bytes as low/high nibbles followed by shift cycles,
// then collects the result bytes and reports the masked CRC.
module crc_decel_host
    import crcdec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  cfg_width,
    input  logic        cfg_reflect_in,
    input  logic        cfg_reflect_out,
    input  logic [31:0] cfg_poly,
    input  logic [31:0] cfg_init,
    input  logic [31:0] cfg_xor,
    input  logic        setup_req,
    input  logic        msg_valid,
    input  logic [7:0]  msg_data,
    input  logic        msg_last,
    output logic        msg_ready,
    output logic [1:0]  dut_cmd,
    output logic [3:0]  dut_data,
    input  logic [7:0]  dut_io_out,
    output logic        busy,
    output logic [31:0] crc_out,
    output logic        crc_valid,
    output logic        cfg_err,
    output logic        err_underflow
);

    localparam logic [3:0] SHIFT_LAST = 4'(SHIFT_CYCLES - 1);

    host_state_e state_r, state_n;
    crc_cfg_t    cfg_r, cfg_n;
    logic [4:0]  setup_idx_r, setup_idx_n;
    logic [3:0]  cyc_r, cyc_n;
    logic [3:0]  hi_nib_r, hi_nib_n;
    logic        last_r, last_n;
    logic [31:0] cap_r, cap_n;

    logic [1:0]  dut_cmd_r, dut_cmd_n;
    logic [3:0]  dut_data_r, dut_data_n;
    logic        msg_ready_r, msg_ready_n;
    logic        busy_r, busy_n;
    logic [31:0] crc_out_r, crc_out_n;
    logic        crc_valid_r, crc_valid_n;
    logic        cfg_err_r, cfg_err_n;
    logic        err_underflow_r, err_underflow_n;

    logic [3:0]  ser_nibble_s;
    logic [4:0]  setup_last_s;
    logic [3:0]  cap_last_s;

    // Last setup index is 2 + 3N, last capture index is B - 1.
    assign setup_last_s = 5'd2 + {1'b0, cfg_r.width[5:2]} + {cfg_r.width[5:2], 1'b0};
    assign cap_last_s   = width_bytes(cfg_r.width) - 4'd1;

    crcdec_setup_serializer u_ser (
        .cfg    (cfg_r),
        .idx    (setup_idx_n),
        .nibble (ser_nibble_s)
    );

    // The low nibble has to be on the port in the same cycle the byte is
    // offered (msg_ready), so it bypasses the output register.
    assign dut_data      = (state_r == MSG_LO) ? (msg_valid ? msg_data[3:0] : 4'h0) : dut_data_r;
    assign dut_cmd       = dut_cmd_r;
    assign msg_ready     = msg_ready_r;
    assign busy          = busy_r;
    assign crc_out       = crc_out_r;
    assign crc_valid     = crc_valid_r;
    assign cfg_err       = cfg_err_r;
    assign err_underflow = err_underflow_r;

    // Next-state logic plus look-ahead decode of the registered outputs.
    always_comb begin
        state_n         = state_r;
        cfg_n           = cfg_r;
        setup_idx_n     = setup_idx_r;
        cyc_n           = cyc_r;
        hi_nib_n        = hi_nib_r;
        last_n          = last_r;
        cap_n           = cap_r;
        crc_out_n       = crc_out_r;
        cfg_err_n       = 1'b0;
        err_underflow_n = err_underflow_r;

        case (state_r)
            IDLE: begin
                if (setup_req) begin
                    err_underflow_n = 1'b0;
                    if (width_legal(cfg_width)) begin
                        cfg_n = '{width: cfg_width, reflect_in: cfg_reflect_in,
                                  reflect_out: cfg_reflect_out, poly: cfg_poly,
                                  init: cfg_init, xorv: cfg_xor};
                        setup_idx_n = 5'd0;
                        state_n     = SETUP_STREAM;
                    end else begin
                        cfg_err_n = 1'b1;
                        state_n   = IDLE;
                    end
                end else if (msg_valid) begin
                    err_underflow_n = 1'b0;
                    cap_n           = 32'd0;
                    last_n          = 1'b0;
                    state_n         = MSG_LEAD;
                end else begin
                    state_n = IDLE;
                end
            end
            SETUP_STREAM: begin
                if (setup_idx_r == setup_last_s) begin
                    state_n = SETUP_EXIT;
                end else begin
                    setup_idx_n = setup_idx_r + 5'd1;
                end
            end
            // Single RESET cycle closing a setup or an abandoned message.
            SETUP_EXIT: begin
                state_n = IDLE;
            end
            MSG_LEAD: begin
                state_n = MSG_LO;
            end
            MSG_LO: begin
                if (msg_valid) begin
                    hi_nib_n = msg_data[7:4];
                    last_n   = msg_last;
                    state_n  = MSG_HI;
                end else begin
                    err_underflow_n = 1'b1;
                    state_n         = SETUP_EXIT;
                end
            end
            MSG_HI: begin
                cyc_n   = 4'd0;
                state_n = MSG_SHIFT;
            end
            MSG_SHIFT: begin
                if (cyc_r == SHIFT_LAST) begin
                    cyc_n   = 4'd0;
                    state_n = last_r ? FINAL_WAIT : MSG_LO;
                end else begin
                    cyc_n = cyc_r + 4'd1;
                end
            end
            FINAL_WAIT: begin
                cyc_n   = 4'd0;
                state_n = FINAL_CAP;
            end
            FINAL_CAP: begin
                cap_n = cap_r | ({24'd0, dut_io_out} << {cyc_r[1:0], 3'b000});
                if (cyc_r == cap_last_s) begin
                    crc_out_n = cap_n & width_mask(cfg_r.width);
                    state_n   = DONE;
                end else begin
                    cyc_n = cyc_r + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            SETUP_STREAM: dut_cmd_n = CMD_SETUP;
            MSG_LEAD:     dut_cmd_n = CMD_MESSAGE;
            MSG_LO:       dut_cmd_n = CMD_MESSAGE;
            MSG_HI:       dut_cmd_n = CMD_MESSAGE;
            MSG_SHIFT:    dut_cmd_n = CMD_MESSAGE;
            FINAL_WAIT:   dut_cmd_n = CMD_FINAL;
            FINAL_CAP:    dut_cmd_n = CMD_FINAL;
            default:      dut_cmd_n = CMD_RESET;
        endcase

        case (state_n)
            SETUP_STREAM: dut_data_n = ser_nibble_s;
            MSG_HI:       dut_data_n = hi_nib_n;
            default:      dut_data_n = 4'h0;
        endcase

        msg_ready_n = (state_n == MSG_LO);
        busy_n      = (state_n != IDLE);
        crc_valid_n = (state_n == DONE);
    end

    // State, configuration and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            cfg_r           <= CFG_RESET;
            setup_idx_r     <= 5'd0;
            cyc_r           <= 4'd0;
            hi_nib_r        <= 4'h0;
            last_r          <= 1'b0;
            cap_r           <= 32'd0;
            dut_cmd_r       <= CMD_RESET;
            dut_data_r      <= 4'h0;
            msg_ready_r     <= 1'b0;
            busy_r          <= 1'b0;
            crc_out_r       <= 32'd0;
            crc_valid_r     <= 1'b0;
            cfg_err_r       <= 1'b0;
            err_underflow_r <= 1'b0;
        end else begin
            state_r         <= state_n;
            cfg_r           <= cfg_n;
            setup_idx_r     <= setup_idx_n;
            cyc_r           <= cyc_n;
            hi_nib_r        <= hi_nib_n;
            last_r          <= last_n;
            cap_r           <= cap_n;
            dut_cmd_r       <= dut_cmd_n;
            dut_data_r      <= dut_data_n;
            msg_ready_r     <= msg_ready_n;
            busy_r          <= busy_n;
            crc_out_r       <= crc_out_n;
            crc_valid_r     <= crc_valid_n;
            cfg_err_r       <= cfg_err_n;
            err_underflow_r <= err_underflow_n;
        end
    end

endmodule

// File: tb/tb_crc_decel_host.sv
// Directed bench for crc_decel_host with a behavioural decelerator that
// decodes the nibble port and returns a CRC computed from what it received.
module tb_crc_decel_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  cfg_width = 6'd0;
    logic        cfg_reflect_in = 1'b0;
    logic        cfg_reflect_out = 1'b0;
    logic [31:0] cfg_poly = 32'd0;
    logic [31:0] cfg_init = 32'd0;
    logic [31:0] cfg_xor = 32'd0;
    logic        setup_req = 1'b0;
    logic        msg_valid = 1'b0;
    logic [7:0]  msg_data = 8'd0;
    logic        msg_last = 1'b0;
    logic        msg_ready;
    logic [1:0]  dut_cmd;
    logic [3:0]  dut_data;
    logic [7:0]  dut_io_out = 8'd0;
    logic        busy;
    logic [31:0] crc_out;
    logic        crc_valid;
    logic        cfg_err;
    logic        err_underflow;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] msg_bytes [16];

    crc_decel_host dut (
        .clk(clk), .rst(rst), .cfg_width(cfg_width),
        .cfg_reflect_in(cfg_reflect_in), .cfg_reflect_out(cfg_reflect_out),
        .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xor(cfg_xor),
        .setup_req(setup_req), .msg_valid(msg_valid), .msg_data(msg_data),
        .msg_last(msg_last), .msg_ready(msg_ready), .dut_cmd(dut_cmd),
        .dut_data(dut_data), .dut_io_out(dut_io_out), .busy(busy),
        .crc_out(crc_out), .crc_valid(crc_valid), .cfg_err(cfg_err),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural decelerator ----------------
    logic [3:0]  snib [32];
    logic [7:0]  mbytes [64];
    logic [3:0]  lo_nib = 4'd0;
    logic [1:0]  prev_cmd = 2'd0;
    int          sq = 0, mp = 0, mlen = 0, fk = 0;
    int          m_w = 32;
    logic        m_ri = 1'b0, m_ro = 1'b0;
    logic [31:0] m_poly = 32'd0, m_init = 32'd0, m_xor = 32'd0, crc_m = 32'd0;

    function automatic int sn_width();
        return int'({snib[2][3:2], snib[1]});
    endfunction

    function automatic logic [31:0] gather(input int base, input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(snib[base + i]) << (4 * i));
        return v;
    endfunction

    function automatic logic [31:0] crc_calc(input int n);
        logic [31:0] c, mask, r;
        logic [7:0]  b;
        logic        fb;
        mask = (m_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << m_w) - 32'd1);
        c = m_init & mask;
        for (int i = 0; i < n; i++) begin
            b = mbytes[i];
            if (m_ri) b = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
            for (int j = 7; j >= 0; j--) begin
                fb = c[m_w - 1] ^ b[j];
                c = (c << 1) & mask;
                if (fb) c = c ^ (m_poly & mask);
            end
        end
        if (m_ro) begin
            r = 32'd0;
            for (int j = 0; j < m_w; j++) r[m_w - 1 - j] = c[j];
            c = r;
        end
        return (c ^ m_xor) & mask;
    endfunction

    // Decelerator model: observes the port on the falling edge, answers on dut_io_out.
    always @(negedge clk) begin
        if (rst) begin
            prev_cmd <= 2'd0; sq <= 0; mp <= 0; mlen <= 0; fk <= 0;
        end else begin
            prev_cmd <= dut_cmd;
            case (dut_cmd)
                2'd1: begin
                    if (prev_cmd != 2'd1) sq <= 0;
                    else begin
                        sq <= sq + 1;
                        if (sq < 31) snib[sq + 1] <= dut_data;
                    end
                end
                2'd2: begin
                    if (prev_cmd != 2'd2) begin
                        mp <= 0; mlen <= 0;
                    end else begin
                        mp <= mp + 1;
                        if (mp % 10 == 0) lo_nib <= dut_data;
                        if ((mp % 10 == 1) && (mlen < 64)) begin
                            mbytes[mlen] <= {dut_data, lo_nib};
                            mlen <= mlen + 1;
                        end
                    end
                end
                2'd3: begin
                    if (prev_cmd != 2'd3) begin
                        crc_m <= crc_calc(mlen); fk <= 0;
                    end else begin
                        dut_io_out <= 8'(crc_m >> (8 * fk)); fk <= fk + 1;
                    end
                end
                default: ;
            endcase
            if ((prev_cmd == 2'd1) && (dut_cmd != 2'd1)) begin
                m_w    <= sn_width();
                m_ri   <= snib[2][0];
                m_ro   <= snib[2][1];
                m_poly <= gather(3, sn_width() / 4);
                m_init <= gather(3 + sn_width() / 4, sn_width() / 4);
                m_xor  <= gather(3 + 2 * (sn_width() / 4), sn_width() / 4);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_setup(input logic [5:0] w, input logic ri, input logic ro,
                             input logic [31:0] p, input logic [31:0] ini, input logic [31:0] x);
        int guard;
        cfg_width = w; cfg_reflect_in = ri; cfg_reflect_out = ro;
        cfg_poly = p; cfg_init = ini; cfg_xor = x;
        setup_req = 1'b1;
        step();
        setup_req = 1'b0;
        guard = 0;
        while (busy && guard < 40) begin step(); guard++; end
        check_eq("setup_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_msg(input int n, input int drop_k, input logic [31:0] exp_crc, input int nb);
        int cyc, k, f_cyc, done_cyc, seen;
        k = 0; f_cyc = -1; done_cyc = -1;
        msg_data = msg_bytes[0]; msg_last = (n == 1); msg_valid = 1'b1;
        step(); cyc = 0;
        check_eq("msg_lead_cmd", {30'd0, dut_cmd}, 32'd2);
        while (cyc < 10 * n + 20) begin
            if ((dut_cmd == 2'd3) && (f_cyc < 0)) f_cyc = cyc;
            if (crc_valid) begin done_cyc = cyc; break; end
            if (msg_ready) begin
                check_eq("ready_slot", cyc, 1 + 10 * k);
                if (k == drop_k) begin
                    step(); cyc++;
                    check_eq("uf_cycle", cyc, 2 + 10 * drop_k);
                    check_eq("uf_reset_cmd", {30'd0, dut_cmd}, 32'd0);
                    check_eq("uf_flag", {31'd0, err_underflow}, 32'd1);
                    seen = 0;
                    for (int i = 0; i < 15; i++) begin
                        if (crc_valid) seen = 1;
                        step();
                    end
                    check_eq("uf_no_crc_valid", seen, 32'd0);
                    check_eq("uf_sticky", {31'd0, err_underflow}, 32'd1);
                    check_eq("uf_idle", {31'd0, busy}, 32'd0);
                    return;
                end
                k++;
                step(); cyc++;
                if (k < n) begin
                    msg_data = msg_bytes[k]; msg_last = (k == n - 1); msg_valid = (k != drop_k);
                end else begin
                    msg_valid = 1'b0; msg_last = 1'b0;
                end
            end else begin
                step(); cyc++;
            end
        end
        check_eq("final_cycle", f_cyc, 10 * n + 1);
        check_eq("done_cycle", done_cyc, 10 * n + 1 + nb + 1);
        check_eq("crc_value", crc_out, exp_crc);
        check_eq("done_cmd", {30'd0, dut_cmd}, 32'd0);
        step();
        check_eq("valid_pulse", {31'd0, crc_valid}, 32'd0);
        check_eq("idle_after", {31'd0, busy}, 32'd0);
        check_eq("crc_hold", crc_out, exp_crc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp25 [14];
        exp25 = '{4'h0, 4'h4, 4'h1, 4'h2, 4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF,
                  4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 0; i < 16; i++) msg_bytes[i] = 8'h31 + 8'(i);

        // Reset state
        step(); step(); step();
        check_eq("rst_cmd", {30'd0, dut_cmd}, 32'd0);
        check_eq("rst_data", {28'd0, dut_data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, msg_ready}, 32'd0);
        check_eq("rst_crc", crc_out, 32'd0);
        rst = 1'b0;
        step();

        // Setup stream for width 16, poly 0x1021, init 0xFFFF
        cfg_width = 6'd16; cfg_reflect_in = 1'b0; cfg_reflect_out = 1'b0;
        cfg_poly = 32'h1021; cfg_init = 32'hFFFF; cfg_xor = 32'd0;
        setup_req = 1'b1;
        step();
        setup_req = 1'b0;
        check_eq("s0_cmd", {30'd0, dut_cmd}, 32'd1);
        check_eq("s0_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            step();
            check_eq("setup_nibble", {28'd0, dut_data}, {28'd0, exp25[i]});
            check_eq("setup_cmd", {30'd0, dut_cmd}, 32'd1);
        end
        step();
        check_eq("setup_exit_cmd", {30'd0, dut_cmd}, 32'd0);
        check_eq("setup_exit_busy", {31'd0, busy}, 32'd1);
        step();
        check_eq("setup_idle", {31'd0, busy}, 32'd0);

        // CRC-8 of "123456789"
        run_setup(6'd8, 1'b0, 1'b0, 32'h07, 32'h0, 32'h0);
        run_msg(9, 99, 32'h0000_00F4, 1);

        // CRC-32 of "123456789"
        run_setup(6'd32, 1'b1, 1'b1, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_msg(9, 99, 32'hCBF4_3926, 4);

        // Underflow at the third byte slot (M+21)
        run_msg(3, 2, 32'd0, 4);

        // Illegal width
        cfg_width = 6'd10;
        setup_req = 1'b1;
        step();
        setup_req = 1'b0;
        check_eq("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
        check_eq("cfg_err_cmd", {30'd0, dut_cmd}, 32'd0);
        check_eq("cfg_err_busy", {31'd0, busy}, 32'd0);
        check_eq("cfg_err_clears_uf", {31'd0, err_underflow}, 32'd0);
        step();
        check_eq("cfg_err_once", {31'd0, cfg_err}, 32'd0);

        // Reset in the middle of a message (rst sampled at the end of M+5)
        msg_data = msg_bytes[0]; msg_last = 1'b0; msg_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        msg_valid = 1'b0;
        check_eq("mrst_cmd", {30'd0, dut_cmd}, 32'd0);
        check_eq("mrst_data", {28'd0, dut_data}, 32'd0);
        check_eq("mrst_busy", {31'd0, busy}, 32'd0);
        check_eq("mrst_ready", {31'd0, msg_ready}, 32'd0);
        check_eq("mrst_crc", crc_out, 32'd0);
        check_eq("mrst_valid", {31'd0, crc_valid}, 32'd0);
        check_eq("mrst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check_eq("mrst_uf", {31'd0, err_underflow}, 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
